herring_sysctl: RTL and testbench

- Memory-mapped system-control responder on the 6502 bus. It is the bus-side counterpart of the address/chip-select decoding logic in the same FPGA.
- Sits at 0x8800–0x8BFF (A15..A10 = 100010); registers mirror every 4 bytes.
- Generates a CPU clock whose rate the CPU can reprogram at run time, glitch-free.
- Also provides a phi2 tick counter and a periodic interrupt timer driving IRQB.

---
 rtl/herring_sysctl.sv | 210 +++++++++++++++++++++
 tb/tb_herring_sysctl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/herring_sysctl.sv
// herring_sysctl: 6502-side system control responder.
// Glitch-free programmable CPU clock, phi2 tick counter and periodic IRQ timer.
module herring_sysctl #(
  parameter int unsigned DEFAULT_INDEX = 19,
  parameter logic [5:0]  BASE_ADDR     = 6'b100010
) (
  input  logic       clk_src,
  input  logic       rst,
  output logic       cpu_clk_in,
  input  logic       cpu_clk_out,
  input  logic [5:0] address,
  input  logic [1:0] reg_sel,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       irq_n
);

  localparam logic [4:0]  DEF_IDX  = 5'(DEFAULT_INDEX);
  localparam logic [25:0] DEF_HALF =
    26'((64'd1 << (DEFAULT_INDEX - 1)) - 64'd1);

  localparam logic [1:0] SEL_DIV  = 2'd0;
  localparam logic [1:0] SEL_REL  = 2'd1;
  localparam logic [1:0] SEL_CTL  = 2'd2;

  typedef struct packed {
    logic [5:0] addr;
    logic [1:0] sel;
    logic       rw;
    logic [7:0] data;
  } bus_t;

  // Half-period minus one, in clk_src cycles, for a divider index.
  function automatic logic [25:0] half_m1(input logic [4:0] idx);
    half_m1 = (26'd1 << (idx - 5'd1)) - 26'd1;
  endfunction

  // Keep the divider index inside the legal 1..26 range.
  function automatic logic [4:0] clamp_idx(input logic [4:0] v);
    if (v == 5'd0) begin
      clamp_idx = 5'd1;
    end else if (v > 5'd26) begin
      clamp_idx = 5'd26;
    end else begin
      clamp_idx = v;
    end
  endfunction

  logic        clk_q, clk_d;
  logic [25:0] cnt_q, cnt_d;
  logic [4:0]  act_q, act_d;

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  bus_t        b1_q, b1_d;
  bus_t        b2_q, b2_d;
  bus_t        b3_q, b3_d;

  logic [4:0]  clkdiv_q, clkdiv_d;
  logic [7:0]  reload_q, reload_d;
  logic        en_q, en_d;
  logic        irqen_q, irqen_d;
  logic        pend_q, pend_d;
  logic [7:0]  tick_q, tick_d;
  logic [7:0]  count_q, count_d;
  logic        irq_n_q, irq_n_d;

  logic        strobe;
  logic        commit;
  logic        wr_div;
  logic        wr_rel;
  logic        wr_ctl;
  logic        expire;

  // Clock divider: toggle at zero, pick up a new index only on the falling toggle.
  always_comb begin
    clk_d = clk_q;
    act_d = act_q;
    cnt_d = cnt_q - 26'd1;
    if (cnt_q == 26'd0) begin
      clk_d = ~clk_q;
      if (clk_q) begin
        act_d = clkdiv_q;
        cnt_d = half_m1(clkdiv_q);
      end else begin
        cnt_d = half_m1(act_q);
      end
    end
  end

  // phi2 synchronizer with the bus sample pipelined alongside it.
  always_comb begin
    s1_d = cpu_clk_out;
    s2_d = s1_q;
    s3_d = s2_q;
    b1_d = '{addr: address, sel: reg_sel, rw: rw, data: data_in};
    b2_d = b1_q;
    b3_d = b2_q;
  end

  // Cycle-end strobe and the write decode for the sample from the last phi2-high cycle.
  always_comb begin
    strobe = ~s2_q & s3_q;
    commit = strobe & (b3_q.addr == BASE_ADDR) & ~b3_q.rw;
    wr_div = commit & (b3_q.sel == SEL_DIV);
    wr_rel = commit & (b3_q.sel == SEL_REL);
    wr_ctl = commit & (b3_q.sel == SEL_CTL);
    expire = strobe & en_q & (count_q == 8'd0);
  end

  // Register file, tick counter and timer updates.
  always_comb begin
    clkdiv_d = clkdiv_q;
    reload_d = reload_q;
    en_d     = en_q;
    irqen_d  = irqen_q;
    pend_d   = pend_q;
    tick_d   = tick_q;
    count_d  = count_q;
    if (wr_div) begin
      clkdiv_d = clamp_idx(b3_q.data[4:0]);
    end
    if (wr_rel) begin
      reload_d = b3_q.data;
    end
    if (wr_ctl) begin
      en_d    = b3_q.data[0];
      irqen_d = b3_q.data[1];
    end
    if (strobe) begin
      tick_d = tick_q + 8'd1;
    end
    if (wr_ctl & b3_q.data[0] & ~en_q) begin
      count_d = reload_q;
    end else if (strobe & en_q) begin
      count_d = expire ? reload_d : count_q - 8'd1;
    end
    if (wr_ctl & b3_q.data[7]) begin
      pend_d = 1'b0;
    end
    if (expire) begin
      pend_d = 1'b1;
    end
  end

  // Registered interrupt output.
  always_comb begin
    irq_n_d = ~(pend_q & irqen_q);
  end

  // All state, async active-high reset.
  always_ff @(posedge clk_src or posedge rst) begin
    if (rst) begin
      clk_q    <= 1'b0;
      cnt_q    <= DEF_HALF;
      act_q    <= DEF_IDX;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      b1_q     <= '0;
      b2_q     <= '0;
      b3_q     <= '0;
      clkdiv_q <= DEF_IDX;
      reload_q <= 8'd0;
      en_q     <= 1'b0;
      irqen_q  <= 1'b0;
      pend_q   <= 1'b0;
      tick_q   <= 8'd0;
      count_q  <= 8'd0;
      irq_n_q  <= 1'b1;
    end else begin
      clk_q    <= clk_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      b3_q     <= b3_d;
      clkdiv_q <= clkdiv_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      irqen_q  <= irqen_d;
      pend_q   <= pend_d;
      tick_q   <= tick_d;
      count_q  <= count_d;
      irq_n_q  <= irq_n_d;
    end
  end

  // Unsynchronized read path for fastest access time.
  always_comb begin
    data_oe  = (address == BASE_ADDR) & rw & cpu_clk_out;
    data_out = 8'h00;
    unique case (reg_sel)
      2'd0: data_out = {3'b000, clkdiv_q};
      2'd1: data_out = reload_q;
      2'd2: data_out = {pend_q, 5'b00000, irqen_q, en_q};
      2'd3: data_out = tick_q;
    endcase
  end

  assign cpu_clk_in = clk_q;
  assign irq_n      = irq_n_q;

endmodule

// File: tb/tb_herring_sysctl.sv
// tb_herring_sysctl: directed bench with a register-level model
// checked every settled cycle, plus literal expectations.
module tb_herring_sysctl;

  localparam logic [5:0] BASE = 6'b100010;
  localparam logic [5:0] IDLE = 6'b000000;

  logic       clk;
  logic       rst;
  logic       cpu_clk_out;
  logic [5:0] address;
  logic [1:0] reg_sel;
  logic       rw;
  logic [7:0] data_in;
  logic       cpu_clk_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       irq_n;

  logic       def_clk;
  logic [7:0] def_dout;
  logic       def_oe;
  logic       def_irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] m_clkdiv;
  logic [7:0] m_reload;
  logic       m_en;
  logic       m_irqen;
  logic       m_pend;
  logic [7:0] m_tick;
  int         m_cnt;

  bit         chk_en = 0;
  bit         def_rose = 0;
  logic [7:0] rd_val;
  logic       rd_oe;
  int         q[$];

  herring_sysctl #(.DEFAULT_INDEX(5)) dut (
    .clk_src(clk), .rst(rst), .cpu_clk_in(cpu_clk_in),
    .cpu_clk_out(cpu_clk_out), .address(address),
    .reg_sel(reg_sel), .rw(rw), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .irq_n(irq_n)
  );

  herring_sysctl u_def (
    .clk_src(clk), .rst(rst), .cpu_clk_in(def_clk),
    .cpu_clk_out(1'b0), .address(IDLE),
    .reg_sel(2'd0), .rw(1'b1), .data_in(8'h00),
    .data_out(def_dout), .data_oe(def_oe), .irq_n(def_irq)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] clamp(input logic [4:0] v);
    if (v == 0) return 5'd1;
    if (v > 26) return 5'd26;
    return v;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] s);
    case (s)
      2'd0: return {3'b000, m_clkdiv};
      2'd1: return m_reload;
      2'd2: return {m_pend, 5'b00000, m_irqen, m_en};
      default: return m_tick;
    endcase
  endfunction

  task automatic model_reset();
    m_clkdiv = 5; m_reload = 0; m_en = 0; m_irqen = 0;
    m_pend = 0; m_tick = 0; m_cnt = 0;
  endtask

  // Rules applied once per completed phi2 cycle.
  task automatic model_strobe(input logic [5:0] a, input logic [1:0] s,
                              input logic r, input logic [7:0] d);
    bit wr;
    bit fire;
    int nrel;
    wr = (a == BASE) && !r;
    fire = m_en && (m_cnt == 0);
    nrel = (wr && s == 1) ? int'(d) : int'(m_reload);
    m_tick = m_tick + 8'd1;
    if (wr && s == 2 && d[0] && !m_en) m_cnt = m_reload;
    else if (m_en) m_cnt = fire ? nrel : m_cnt - 1;
    if (wr && s == 0) m_clkdiv = clamp(d[4:0]);
    if (wr && s == 1) m_reload = d;
    if (wr && s == 2) begin
      m_en = d[0];
      m_irqen = d[1];
    end
    m_pend = fire || (m_pend && !(wr && s == 2 && d[7]));
  endtask

  // One 6502 bus cycle: 8 clocks low, 4 clocks high.
  task automatic bus_cycle(input logic [5:0] a, input logic [1:0] s,
                           input logic r, input logic [7:0] d);
    address = a; reg_sel = s; rw = r; data_in = d;
    repeat (4) @(posedge clk);
    #1 cpu_clk_out = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd_val = data_out;
    rd_oe = data_oe;
    @(posedge clk);
    #1;
    chk_en = 0;
    cpu_clk_out = 0;
    repeat (4) @(posedge clk);
    #1;
    model_strobe(a, s, r, d);
    chk_en = 1;
  endtask

  task automatic idle();
    bus_cycle(IDLE, 2'd0, 1'b1, 8'h00);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Phase lengths from `from` on: old lengths, then new ones, switching after a high phase.
  task automatic check_switch(input string nm, input int from,
                              input int oh, input int nh);
    int i;
    int n_old;
    int n_new;
    i = from; n_old = 0; n_new = 0;
    while (i < q.size() && q[i] == oh) begin n_old++; i++; end
    while (i < q.size() && q[i] == nh) begin n_new++; i++; end
    chk({nm, " stray phases"}, q.size() - i, 0);
    chk({nm, " old seen"}, n_old >= 1, 1);
    chk({nm, " new seen"}, n_new >= 3, 1);
    chk({nm, " switch after high"}, (from + n_old) % 2, 0);
  endtask

  // Phase-length log of cpu_clk_in; entry 0 is the low phase after reset.
  initial begin
    int run;
    logic last;
    run = 0; last = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        run = 0; last = 0; q.delete();
      end else if (cpu_clk_in !== last) begin
        q.push_back(run);
        run = 1;
        last = cpu_clk_in;
      end else begin
        run++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (def_clk === 1'b1) def_rose = 1;
    end
  end

  // Model compare on every settled cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        chk("cmp data_out", data_out, exp_rd(reg_sel));
        chk("cmp data_oe", data_oe,
            (address == BASE) && rw && cpu_clk_out);
        chk("cmp irq_n", irq_n, !(m_pend && m_irqen));
      end
    end
  end

  initial begin
    int n;
    int mark;
    rst = 1; cpu_clk_out = 0; address = IDLE;
    reg_sel = 0; rw = 1; data_in = 0;
    model_reset();
    wait_clk(3);
    chk("reset cpu_clk_in", cpu_clk_in, 0);
    chk("reset irq_n", irq_n, 1);
    chk("reset data_oe", data_oe, 0);
    chk("reset clkdiv", data_out, 8'h05);
    chk("default clkdiv", def_dout, 8'd19);
    reg_sel = 3;
    #1 chk("reset tick", data_out, 8'h00);
    reg_sel = 0;
    wait_clk(1);
    rst = 0;
    chk_en = 1;
    wait_clk(40);
    chk("first phases logged", q.size() >= 2, 1);
    if (q.size() >= 2) begin
      chk("first low half", q[0], 16);
      chk("first high half", q[1], 16);
    end

    mark = q.size();
    bus_cycle(BASE, 2'd0, 1'b0, 8'h01);
    wait_clk(60);
    check_switch("div 5->1", mark, 16, 1);
    bus_cycle(BASE, 2'd0, 1'b1, 8'h00);
    chk("clkdiv readback 1", rd_val, 8'h01);
    chk("clkdiv read oe", rd_oe, 1);

    mark = q.size();
    bus_cycle(BASE, 2'd0, 1'b0, 8'h03);
    wait_clk(80);
    check_switch("div 1->3", mark, 1, 4);
    bus_cycle(BASE, 2'd0, 1'b1, 8'h00);
    chk("clkdiv readback 3", rd_val, 8'h03);

    bus_cycle(BASE, 2'd3, 1'b1, 8'h00);
    chk("tick read", rd_val, 8'd4);
    chk("tick read oe", rd_oe, 1);
    bus_cycle(6'b100001, 2'd3, 1'b1, 8'h00);
    chk("other page oe", rd_oe, 0);
    bus_cycle(BASE, 2'd3, 1'b0, 8'h55);

    bus_cycle(BASE, 2'd1, 1'b0, 8'h03);
    bus_cycle(BASE, 2'd2, 1'b0, 8'h03);
    n = 0;
    do begin
      idle();
      n++;
    end while (irq_n !== 1'b0 && n < 12);
    chk("first expiry cycles", n, 4);
    bus_cycle(BASE, 2'd2, 1'b0, 8'h83);
    chk("irq_n after clear", irq_n, 1);
    n = 0;
    do begin
      idle();
      n++;
    end while (irq_n !== 1'b0 && n < 12);
    chk("re-expiry idle cycles", n, 3);

    bus_cycle(BASE, 2'd2, 1'b0, 8'h83);
    idle();
    idle();
    bus_cycle(BASE, 2'd2, 1'b0, 8'h83);
    chk("set beats clear", irq_n, 0);

    bus_cycle(BASE, 2'd2, 1'b0, 8'h83);
    idle();
    idle();
    bus_cycle(BASE, 2'd1, 1'b0, 8'h01);
    chk("expiry with reload write", irq_n, 0);
    bus_cycle(BASE, 2'd2, 1'b0, 8'h83);
    chk("cleared before new period", irq_n, 1);
    idle();
    chk("new reload period", irq_n, 0);

    bus_cycle(BASE, 2'd2, 1'b0, 8'h02);
    idle();
    idle();
    idle();
    chk("pending kept when off", irq_n, 0);
    bus_cycle(BASE, 2'd2, 1'b1, 8'h00);
    chk("ctrl readback", rd_val, 8'h82);

    n = 0;
    while (m_tick != 8'd255 && n < 300) begin
      idle();
      n++;
    end
    bus_cycle(BASE, 2'd3, 1'b1, 8'h00);
    chk("tick 255", rd_val, 8'd255);
    bus_cycle(BASE, 2'd3, 1'b1, 8'h00);
    chk("tick wrap", rd_val, 8'd0);

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_clk_in !== 1'b1 && n < 100);
    chk("clock high before reset", cpu_clk_in, 1);
    chk_en = 0;
    #2 rst = 1;
    #1;
    chk("mid reset cpu_clk_in", cpu_clk_in, 0);
    chk("mid reset irq_n", irq_n, 1);
    chk("mid reset data_oe", data_oe, 0);
    chk("mid reset tick", data_out, 8'h00);
    reg_sel = 2;
    #1 chk("mid reset ctrl", data_out, 8'h00);
    reg_sel = 0;
    #1 chk("mid reset clkdiv", data_out, 8'h05);
    model_reset();
    wait_clk(3);
    rst = 0;
    chk_en = 1;
    wait_clk(40);
    chk("restart phases logged", q.size() >= 2, 1);
    if (q.size() >= 2) begin
      chk("restart low half", q[0], 16);
      chk("restart high half", q[1], 16);
    end

    bus_cycle(BASE, 2'd0, 1'b0, 8'h00);
    bus_cycle(BASE, 2'd0, 1'b1, 8'h00);
    chk("clamp low", rd_val, 8'h01);
    bus_cycle(BASE, 2'd0, 1'b0, 8'h1F);
    bus_cycle(BASE, 2'd0, 1'b1, 8'h00);
    chk("clamp high", rd_val, 8'h1A);

    chk("default clock still low", def_rose, 0);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
